// File: rtl/gen_gr_sb.sv
// General-register file with two bypassed read ports, one write port,
// a per-register busy scoreboard and a hardware clear sweep.
module gen_gr_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic            clk_20M,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_n,
  input  logic            rs1,
  output logic [XLEN-1:0] s1_rd,
  output logic            rs1_busy,
  input  logic [AW-1:0]   rs2_n,
  input  logic            rs2,
  output logic [XLEN-1:0] s2_rd,
  output logic            rs2_busy,
  input  logic [AW-1:0]   rd_n,
  input  logic [XLEN-1:0] wd,
  input  logic            rd,
  input  logic            busy_set,
  input  logic [AW-1:0]   busy_n,
  input  logic            clr_req,
  output logic            ready
);

  localparam int unsigned LAST = NREG - 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_nx;
  logic [AW-1:0]     cptr, cptr_nx;
  logic              ready_nx;
  logic [NREG-1:0]   busy, busy_nx;
  logic [XLEN-1:0]   gr [NREG];
  logic              we;
  logic [AW-1:0]     widx;
  logic [XLEN-1:0]   wdat;
  logic              run;
  logic              byp1, byp2;

  assign run = (state == RUN);

  // State, sweep pointer, ready flag and scoreboard
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cptr  <= AW'(1);
      ready <= 1'b0;
      busy  <= '0;
    end else begin
      state <= state_nx;
      cptr  <= cptr_nx;
      ready <= ready_nx;
      busy  <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cptr_nx  = cptr;
    ready_nx = ready;
    busy_nx  = busy;
    we       = 1'b0;
    widx     = cptr;
    wdat     = '0;
    unique case (state)
      CLEAR: begin
        we      = 1'b1;
        busy_nx = '0;
        if (clr_req) begin
          cptr_nx = AW'(1);
        end else if (cptr == AW'(LAST)) begin
          state_nx = RUN;
          ready_nx = 1'b1;
        end else begin
          cptr_nx = cptr + AW'(1);
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nx = CLEAR;
          cptr_nx  = AW'(1);
          ready_nx = 1'b0;
          busy_nx  = '0;
        end else begin
          if (rd && rd_n != '0) begin
            we            = 1'b1;
            widx          = rd_n;
            wdat          = wd;
            busy_nx[rd_n] = 1'b0;
          end
          // New producer overrides a completing write to the same index
          if (busy_set && busy_n != '0) busy_nx[busy_n] = 1'b1;
        end
      end
      default: state_nx = CLEAR;
    endcase
    busy_nx[0] = 1'b0;
  end

  // Register array is deliberately not reset; the sweep initialises it
  always_ff @(posedge clk_20M) begin
    if (we) gr[widx] <= wdat;
  end

  assign byp1 = rd && (rd_n == rs1_n);
  assign byp2 = rd && (rd_n == rs2_n);

  always_comb begin
    s1_rd = '0;
    if (run && rs1 && rs1_n != '0) s1_rd = byp1 ? wd : gr[rs1_n];
  end

  always_comb begin
    s2_rd = '0;
    if (run && rs2 && rs2_n != '0) s2_rd = byp2 ? wd : gr[rs2_n];
  end

  assign rs1_busy = run && rs1 && busy[rs1_n] && !byp1;
  assign rs2_busy = run && rs2 && busy[rs2_n] && !byp2;

endmodule
